// File: rtl/button_debounce_fsm.sv
// Debounce FSM for one push-button: 2-flop synchroniser, tick-counted stability
// check in each direction, clean level, press/release pulses and a press counter.
module button_debounce_fsm #(
  parameter int STABLE_COUNT = 4,
  parameter int CNT_W        = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       sample_tick,
  output logic       timer_en,
  output logic       btn_clean,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] press_count,
  output logic [1:0] state_dbg
);

  // Encoding is visible on state_dbg: LOW=0, CHK_HIGH=1, HIGH=2, CHK_LOW=3.
  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             sync1, btn_s;
  logic             clean_d, press_d, release_d;
  logic [7:0]       count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      btn_s <= sync1;
    end
  end

  // Timer contract: timer_en is high only while checking; sample_tick is a
  // single-cycle pulse that is consumed only in CHK_HIGH / CHK_LOW.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    clean_d   = btn_clean;
    press_d   = 1'b0;
    release_d = 1'b0;
    count_d   = press_count;
    case (state)
      LOW: begin
        if (btn_s) begin
          state_d = CHK_HIGH;
          cnt_d   = '0;
        end
      end
      CHK_HIGH: begin
        // An abort level takes priority over a coincident tick.
        if (!btn_s) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (sample_tick) begin
          if (cnt == CNT_MAX) begin
            state_d = HIGH;
            cnt_d   = '0;
            clean_d = 1'b1;
            press_d = 1'b1;
            count_d = press_count + 8'd1;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      HIGH: begin
        if (!btn_s) begin
          state_d = CHK_LOW;
          cnt_d   = '0;
        end
      end
      CHK_LOW: begin
        if (btn_s) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (sample_tick) begin
          if (cnt == CNT_MAX) begin
            state_d   = LOW;
            cnt_d     = '0;
            clean_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LOW;
      cnt           <= '0;
      btn_clean     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      btn_clean     <= clean_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      press_count   <= count_d;
    end
  end

  assign timer_en  = (state == CHK_HIGH) || (state == CHK_LOW);
  assign state_dbg = state;

endmodule

// File: tb/tb_button_debounce_fsm.sv
// Bench for button_debounce_fsm: directed stimulus pushes expected pulse events,
// a negedge monitor pops and compares them whenever a pulse appears.
module tb_button_debounce_fsm;

  localparam int W = 11;  // {press, release, clean, count[7:0]}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_raw = 1'b0;
  logic       sample_tick = 1'b0;
  logic       timer_en, btn_clean, press_pulse, release_pulse;
  logic [7:0] press_count;
  logic [1:0] state_dbg;

  logic [W-1:0] exp_q[$];
  logic [7:0]   exp_count = 8'd0;
  int           n_tests = 0;
  int           n_fail  = 0;
  logic         saw_low;

  button_debounce_fsm dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .sample_tick(sample_tick),
    .timer_en(timer_en), .btn_clean(btn_clean), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .press_count(press_count), .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic ticks_gap(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      repeat (gap) step();
      tick();
    end
  endtask

  // Drive a level, let it settle into the check state, then four ticks; the
  // final tick must produce the accept event.
  task automatic accept_level(input logic lvl, input int gap);
    btn_raw = lvl;
    repeat (3) step();
    ticks_gap(3, gap);
    if (lvl) exp_q.push_back({1'b1, 1'b0, 1'b1, exp_count + 8'd1});
    else     exp_q.push_back({1'b0, 1'b1, 1'b0, exp_count});
    ticks_gap(1, gap);
    if (lvl) exp_count = exp_count + 8'd1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] got, exp;
    if (!rst && (press_pulse || release_pulse)) begin
      got = {press_pulse, release_pulse, btn_clean, press_count};
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got %0h expected no pulse", got);
      end else begin
        exp = exp_q.pop_front();
        check("pulse_event", 32'(got), 32'(exp));
      end
    end
  end

  initial begin
    // Reset
    step();
    step();
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_outputs", {28'd0, timer_en, btn_clean, press_pulse, release_pulse}, 32'd0);
    check("rst_count", 32'(press_count), 32'd0);
    rst = 1'b0;

    // Clean press with timer_en latency
    btn_raw = 1'b1;
    step();
    step();
    check("timer_en_before_3clk", 32'(timer_en), 32'd0);
    step();
    check("timer_en_at_3clk", 32'(timer_en), 32'd1);
    check("state_chk_high", 32'(state_dbg), 32'd1);
    ticks_gap(3, 9);
    check("clean_before_4th_tick", 32'(btn_clean), 32'd0);
    exp_q.push_back({1'b1, 1'b0, 1'b1, exp_count + 8'd1});
    ticks_gap(1, 9);
    exp_count = exp_count + 8'd1;
    check("clean_after_press", 32'(btn_clean), 32'd1);
    check("state_high", 32'(state_dbg), 32'd2);
    check("timer_en_high", 32'(timer_en), 32'd0);
    step();
    check("press_pulse_one_cycle", 32'(press_pulse), 32'd0);

    // Release
    accept_level(1'b0, 9);
    check("clean_after_release", 32'(btn_clean), 32'd0);
    check("count_after_release", 32'(press_count), 32'(exp_count));
    step();
    check("release_pulse_one_cycle", 32'(release_pulse), 32'd0);

    // Bounce: two ticks, a short low, then the check restarts from zero
    btn_raw = 1'b1;
    repeat (3) step();
    ticks_gap(2, 9);
    btn_raw = 1'b0;
    saw_low = 1'b0;
    repeat (5) begin
      step();
      if (!timer_en) saw_low = 1'b1;
    end
    check("bounce_timer_dropped", 32'(saw_low), 32'd1);
    btn_raw = 1'b1;
    repeat (3) step();
    check("bounce_rechk", 32'(state_dbg), 32'd1);
    ticks_gap(3, 9);
    check("bounce_clean_after_3", 32'(btn_clean), 32'd0);
    exp_q.push_back({1'b1, 1'b0, 1'b1, exp_count + 8'd1});
    ticks_gap(1, 9);
    exp_count = exp_count + 8'd1;
    check("bounce_clean_after_4", 32'(btn_clean), 32'd1);
    check("bounce_count", 32'(press_count), 32'(exp_count));
    accept_level(1'b0, 9);

    // Tie: btn_s falls in the same cycle as the final tick
    btn_raw = 1'b1;
    repeat (3) step();
    ticks_gap(3, 9);
    btn_raw = 1'b0;
    step();
    step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("tie_state_low", 32'(state_dbg), 32'd0);
    check("tie_clean", 32'(btn_clean), 32'd0);
    check("tie_timer_en", 32'(timer_en), 32'd0);
    check("tie_count", 32'(press_count), 32'(exp_count));
    repeat (3) step();

    // Wrap: 256 presses from a fresh count
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_count = 8'd0;
    for (int i = 0; i < 256; i++) begin
      accept_level(1'b1, 1);
      if (i == 254) check("count_255", 32'(press_count), 32'd255);
      accept_level(1'b0, 1);
    end
    check("count_wrapped", 32'(press_count), 32'(exp_count));
    check("count_wrapped_zero", 32'(exp_count), 32'(press_count == 8'd0 ? 8'd0 : 8'd1));

    // Reset during CHK_HIGH
    btn_raw = 1'b1;
    repeat (3) step();
    tick();
    step();
    check("mid_chk_timer_en", 32'(timer_en), 32'd1);
    rst = 1'b1;
    btn_raw = 1'b0;
    step();
    check("mid_rst_state", 32'(state_dbg), 32'd0);
    check("mid_rst_timer_en", 32'(timer_en), 32'd0);
    check("mid_rst_clean", 32'(btn_clean), 32'd0);
    check("mid_rst_count", 32'(press_count), 32'd0);
    rst = 1'b0;
    exp_count = 8'd0;
    repeat (5) step();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
